// File: rtl/ras_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ras_ctrl
//  Purpose  : Return-address-stack controller with speculative IF push/pop and
//             flush-time pointer rollback. Optional counters: RAS_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ras_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PL_stall,
    input  logic          PL_flush,
    input  logic          RAS_push,
    input  logic          RAS_pop,
    input  logic [31:0]   push_data,
    input  logic          RAS_rollback_pop_id,
    input  logic          RAS_rollback_push_id,
    input  logic          RAS_rollback_push_ex,
    output logic [31:0]   top_data,
    output logic          top_valid,
    output logic [AW:0]   cnt,
    output logic [15:0]   stat_ovf,
    output logic [15:0]   stat_udf
);

    localparam logic [AW:0]          C_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic signed [AW+2:0] C_DEPTH_S   = (AW+3)'(DEPTH);
    localparam logic [AW-1:0]        C_ONE_PTR   = AW'(1);

    logic [31:0]  r_mem [DEPTH];
    logic [AW-1:0] r_tos;
    logic [AW:0]   r_cnt;

    logic [AW-1:0] w_tos_m1;
    logic [AW-1:0] w_tos_nxt;
    logic [AW:0]   w_cnt_nxt;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic          w_if_act;
    logic signed [AW+2:0] w_cnt_roll;

    assign w_tos_m1  = r_tos - C_ONE_PTR;
    assign top_data  = r_mem[w_tos_m1];
    assign top_valid = (r_cnt != '0);
    assign cnt       = r_cnt;
    assign w_if_act  = !PL_flush && !PL_stall;

    // Rollback delta is -2..+1, so a signed sum wide enough for cnt-2 and cnt+1.
    assign w_cnt_roll = $signed({2'b00, r_cnt})
                      + $signed({{(AW+2){1'b0}}, RAS_rollback_pop_id})
                      - $signed({{(AW+2){1'b0}}, RAS_rollback_push_id})
                      - $signed({{(AW+2){1'b0}}, RAS_rollback_push_ex});

    always_comb begin
        w_tos_nxt = r_tos;
        w_cnt_nxt = r_cnt;
        w_wr_en   = 1'b0;
        w_wr_addr = r_tos;
        if (PL_flush) begin
            w_tos_nxt = r_tos
                      + {{(AW-1){1'b0}}, RAS_rollback_pop_id}
                      - {{(AW-1){1'b0}}, RAS_rollback_push_id}
                      - {{(AW-1){1'b0}}, RAS_rollback_push_ex};
            if (w_cnt_roll < 0)
                w_cnt_nxt = '0;
            else if (w_cnt_roll > C_DEPTH_S)
                w_cnt_nxt = C_DEPTH_CNT;
            else
                w_cnt_nxt = w_cnt_roll[AW:0];
        end else if (!PL_stall) begin
            if (RAS_push && RAS_pop && (r_cnt != '0)) begin
                // Return-then-call: replace the top in place.
                w_wr_en   = 1'b1;
                w_wr_addr = w_tos_m1;
            end else if (RAS_push) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_tos;
                w_tos_nxt = r_tos + C_ONE_PTR;
                if (r_cnt != C_DEPTH_CNT)
                    w_cnt_nxt = r_cnt + 1'b1;
            end else if (RAS_pop && (r_cnt != '0)) begin
                w_tos_nxt = w_tos_m1;
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_tos <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr_en)
                r_mem[w_wr_addr] <= push_data;
            r_tos <= w_tos_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

`ifdef RAS_STATS_EN
    logic [15:0] r_stat_ovf;
    logic [15:0] r_stat_udf;
    logic        w_ovf_evt;
    logic        w_udf_evt;

    assign w_ovf_evt = w_if_act && RAS_push && !RAS_pop && (r_cnt == C_DEPTH_CNT);
    assign w_udf_evt = w_if_act && RAS_pop && !RAS_push && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ovf <= '0;
            r_stat_udf <= '0;
        end else begin
            if (w_ovf_evt && (r_stat_ovf != 16'hFFFF))
                r_stat_ovf <= r_stat_ovf + 16'd1;
            if (w_udf_evt && (r_stat_udf != 16'hFFFF))
                r_stat_udf <= r_stat_udf + 16'd1;
        end
    end

    assign stat_ovf = r_stat_ovf;
    assign stat_udf = r_stat_udf;
`else
    logic w_unused;
    assign w_unused = w_if_act;
    assign stat_ovf = 16'h0000;
    assign stat_udf = 16'h0000;
`endif

endmodule
`default_nettype wire
